rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- Small in-order-retire reorder buffer that sits directly upstream of regfile and drives its single write port (we_1, write_reg1, write_reg1_data).
- Instructions allocate entries in program order. Execution units write results back out of order by tag.
- Completed results retire strictly in allocation order, one per cycle.
- Serves as the out-of-order comparison point for the Sample MIPS pipeline.

Parameters:
- WIDTH, 16, data width; matches regfile WIDTH.
- REGS, 64, architectural register count; matches regfile DEPTH. Register index width RA = $clog2(REGS).
- ENTRIES, 8, buffer depth. Must be a power of 2, at least 2. Tag width TA = $clog2(ENTRIES).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  1  request to allocate one entry this cycle.
- alloc_dest  in  RA  destination register of the allocating instruction.
- alloc_ready  out  1  entry available; combinational, equals (count < ENTRIES).
- alloc_tag  out  TA  tag given to the allocation this cycle; equals tail pointer.
- wb_valid  in  1  result writeback strobe.
- wb_tag  in  TA  tag of the result.
- wb_data  in  WIDTH  result value.
- flush  in  1  synchronous discard of all entries.
- commit_we  out  1  registered; connects to regfile we_1.
- commit_reg  out  RA  registered; connects to regfile write_reg1.
- commit_data  out  WIDTH  registered; connects to regfile write_reg1_data.
- empty  out  1  combinational, equals (count == 0).
- count  out  TA+1  registered occupancy.

Behaviour:
- State:
  - head and tail pointers, each TA bits, wrapping modulo ENTRIES.
  - count register, TA+1 bits.
  - per entry: busy, done, dest, data.
- Reset (rst_n low, asynchronous):
  - head = tail = count = 0; all busy/done bits = 0.
  - commit_we = 0, commit_reg = 0, commit_data = 0.
  - Therefore alloc_ready = 1, empty = 1, alloc_tag = 0.
  - Reset asserted mid-operation discards all entries immediately.
- Allocate fire = alloc_valid & alloc_ready:
  - entry[tail] gets busy = 1, done = 0, dest = alloc_dest.
  - tail increments.
  - alloc_tag is valid in the same cycle as the request.
- Writeback: when wb_valid & entry[wb_tag].busy & !entry[wb_tag].done, the entry gets done = 1 and data = wb_data.
  - Writeback to a non-busy entry is ignored.
  - Writeback to an already-done entry is ignored; the first value wins.
- Commit fire = entry[head].busy & entry[head].done:
  - At the clock edge: commit_we <= (dest != 0), commit_reg <= dest, commit_data <= data.
  - entry[head].busy and done are cleared; head increments.
  - When commit fire is not set, commit_we <= 0; commit_reg and commit_data hold their values.
- Destination register 0: the entry retires normally (head advances, count decrements) with commit_we = 0.
- Latency: a writeback presented in cycle t to the head entry gives commit_we = 1 in cycle t+2. There is no bypass from wb to commit.
- Throughput: at most one allocation, one writeback and one commit per cycle.
- count update: count <= count + alloc_fire - commit_fire. Simultaneous alloc and commit leaves count unchanged.
- Full (count == ENTRIES):
  - alloc_ready = 0 even if a commit fires in the same cycle; there is no same-cycle slot reuse.
  - alloc_valid is ignored.
- Allocation and writeback to the same tag in the same cycle cannot occur legally (the entry is not busy yet). The writeback is ignored.
- Flush (synchronous, highest priority):
  - Clears every busy/done bit; head = tail = count = 0.
  - commit_we <= 0 at that edge.
  - Allocate, writeback and commit in the same cycle are all discarded.
- Pointer wrap-around: after tag ENTRIES-1 the next tag is 0. Full and empty are told apart by count only.

Test Plan:
- Reset: pulse rst_n low for 2 cycles, release -> commit_we = 0, count = 0, empty = 1, alloc_ready = 1, alloc_tag = 0. Assert rst_n asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
- In order: allocate dest 3 (tag 0); writeback tag 0 with 0x1234 in cycle t -> commit_we = 1, commit_reg = 3, commit_data = 0x1234 in cycle t+2 only; then empty = 1.
- Out of order:
  - Allocate dests 5, 6, 7 (tags 0, 1, 2).
  - Write back tag 2 = 0xCCCC, then tag 1 = 0xBBBB, then tag 0 = 0xAAAA.
  - Required: no commit before tag 0 is written back. Then three consecutive commits: (5, 0xAAAA), (6, 0xBBBB), (7, 0xCCCC).
- Full and wrap-around:
  - Allocate 8 entries without writebacks -> count = 8, alloc_ready = 0. A 9th alloc_valid is ignored.
  - Write back tag 0 -> one commit; count = 7, alloc_ready = 1, next alloc_tag = 0.
  - Write back repeated tag 1 with 0x1111 then 0x2222 -> commits 0x1111.
- Destination register 0: allocate dest 0, write back 0xFFFF -> commit_we stays 0; count decrements from 1 to 0; head advances so the next allocation gets tag 1.
- Flush:
  - Allocate 4 entries, write back 2 of them.
  - Assert flush together with alloc_valid and wb_valid -> next cycle count = 0, empty = 1, commit_we = 0, alloc_tag = 0.
  - No later commit of the flushed data.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: small in-order-retire reorder buffer feeding one regfile write port.
// Entries are allocated in program order, results are written back by tag in any
// order, and completed entries retire strictly from the head, one per cycle.
module rob_commit #(
  parameter int WIDTH   = 16,
  parameter int REGS    = 64,
  parameter int ENTRIES = 8,
  localparam int RA     = $clog2(REGS),
  localparam int TA     = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  // allocation (program order)
  input  logic             alloc_valid,
  input  logic [RA-1:0]    alloc_dest,
  output logic             alloc_ready,
  output logic [TA-1:0]    alloc_tag,
  // out-of-order result writeback
  input  logic             wb_valid,
  input  logic [TA-1:0]    wb_tag,
  input  logic [WIDTH-1:0] wb_data,
  // pipeline flush
  input  logic             flush,
  // regfile write port
  output logic             commit_we,
  output logic [RA-1:0]    commit_reg,
  output logic [WIDTH-1:0] commit_data,
  // occupancy
  output logic             empty,
  output logic [TA:0]      count
);

  // Occupancy value meaning "every entry in use".
  localparam logic [TA:0] COUNT_FULL = (TA+1)'(ENTRIES);

  logic [TA-1:0]      head_q;
  logic [TA-1:0]      tail_q;
  logic [ENTRIES-1:0] busy_q;
  logic [ENTRIES-1:0] done_q;
  logic [RA-1:0]      dest_mem [ENTRIES];
  logic [WIDTH-1:0]   data_mem [ENTRIES];

  logic               alloc_fire;
  logic               wb_fire;
  logic               commit_fire;
  logic [TA:0]        count_next;

  // Full and empty are distinguished by count alone since head == tail in both.
  // A commit in the same cycle does not free a slot for allocation.
  assign alloc_ready = (count < COUNT_FULL);
  assign empty       = (count == '0);
  assign alloc_tag   = tail_q;

  assign alloc_fire  = alloc_valid & alloc_ready;
  // A tag that is not busy (including the one being allocated this cycle) or is
  // already done ignores the writeback, so the first result always wins.
  assign wb_fire     = wb_valid & busy_q[wb_tag] & ~done_q[wb_tag];
  assign commit_fire = busy_q[head_q] & done_q[head_q];

  // Next occupancy: simultaneous allocate and commit cancel out.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the signal unassigned, which would infer a latch.
    count_next = count;
    unique case ({alloc_fire, commit_fire})
      2'b10:   count_next = count + (TA+1)'(1);
      2'b01:   count_next = count - (TA+1)'(1);
      default: count_next = count;
    endcase
  end

  // Pointer, occupancy and per-entry status bits; flush outranks all other updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      count  <= '0;
      busy_q <= '0;
      done_q <= '0;
    end else begin
      // Head and tail never alias while an allocation fires (tail slot is free),
      // and a writeback only targets busy, not-done entries, so these bit
      // updates never collide.
      if (commit_fire) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + TA'(1);
      end
      if (alloc_fire) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        tail_q         <= tail_q + TA'(1);
      end
      if (wb_fire) begin
        done_q[wb_tag] <= 1'b1;
      end
      count <= count_next;
    end
  end

  // Entry payload storage: destination on allocate, result on writeback.
  always_ff @(posedge clk) begin
    // NOTE: payload arrays are left unreset; they are only read once the busy/done bits, which are reset, mark them valid.
    if (alloc_fire && !flush) begin
      dest_mem[tail_q] <= alloc_dest;
    end
    if (wb_fire && !flush) begin
      data_mem[wb_tag] <= wb_data;
    end
  end

  // Registered regfile write port; register 0 retires without a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_we   <= 1'b0;
      commit_reg  <= '0;
      commit_data <= '0;
    end else if (flush) begin
      commit_we <= 1'b0;
    end else if (commit_fire) begin
      commit_we   <= (dest_mem[head_q] != '0);
      commit_reg  <= dest_mem[head_q];
      commit_data <= data_mem[head_q];
    end else begin
      commit_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed and randomized stimulus for rob_commit, checked against
// a program-order queue model of the reorder buffer.
module tb_rob_commit;

  localparam int WIDTH   = 16;
  localparam int REGS    = 64;
  localparam int ENTRIES = 8;
  localparam int RA      = $clog2(REGS);
  localparam int TA      = $clog2(ENTRIES);

  logic             clk;
  logic             rst_n;
  logic             alloc_valid;
  logic [RA-1:0]    alloc_dest;
  logic             alloc_ready;
  logic [TA-1:0]    alloc_tag;
  logic             wb_valid;
  logic [TA-1:0]    wb_tag;
  logic [WIDTH-1:0] wb_data;
  logic             flush;
  logic             commit_we;
  logic [RA-1:0]    commit_reg;
  logic [WIDTH-1:0] commit_data;
  logic             empty;
  logic [TA:0]      count;

  int checks = 0;
  int errors = 0;

  rob_commit #(.WIDTH(WIDTH), .REGS(REGS), .ENTRIES(ENTRIES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_valid (alloc_valid),
    .alloc_dest  (alloc_dest),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .flush       (flush),
    .commit_we   (commit_we),
    .commit_reg  (commit_reg),
    .commit_data (commit_data),
    .empty       (empty),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: outstanding instructions in program order.
  typedef struct {
    logic [TA-1:0]    tag;
    logic [RA-1:0]    dest;
    bit               done;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t             rob_q[$];
  int               next_tag;
  logic             m_we;
  logic [RA-1:0]    m_reg;
  logic [WIDTH-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rob_q.delete();
    next_tag = 0;
    m_we     = 1'b0;
    m_reg    = '0;
    m_data   = '0;
  endtask

  // One clock edge of the model, using pre-edge state for every decision.
  task automatic model_step(input bit av, input logic [RA-1:0] ad, input bit wv,
                            input logic [TA-1:0] wt, input logic [WIDTH-1:0] wd,
                            input bit fl);
    bit   ready;
    bit   retire;
    ent_t e;
    ready  = rob_q.size() < ENTRIES;
    retire = (rob_q.size() > 0) && rob_q[0].done;
    if (fl) begin
      rob_q.delete();
      next_tag = 0;
      m_we     = 1'b0;
    end else begin
      if (wv) begin
        for (int i = 0; i < rob_q.size(); i++) begin
          if (rob_q[i].tag == wt && !rob_q[i].done) begin
            e      = rob_q[i];
            e.done = 1'b1;
            e.data = wd;
            rob_q[i] = e;
          end
        end
      end
      if (retire) begin
        m_we   = (rob_q[0].dest != 0);
        m_reg  = rob_q[0].dest;
        m_data = rob_q[0].data;
        void'(rob_q.pop_front());
      end else begin
        m_we = 1'b0;
      end
      if (av && ready) begin
        e.tag  = TA'(next_tag);
        e.dest = ad;
        e.done = 1'b0;
        e.data = '0;
        rob_q.push_back(e);
        next_tag = (next_tag + 1) % ENTRIES;
      end
    end
  endtask

  task automatic check_regs();
    check("count", 32'(count), 32'(rob_q.size()));
    check("we", 32'(commit_we), 32'(m_we));
    check("reg", 32'(commit_reg), 32'(m_reg));
    check("data", 32'(commit_data), 32'(m_data));
  endtask

  // Drive one cycle of inputs, check combinational outputs before the edge and
  // registered outputs just after it.
  task automatic step(input bit av, input logic [RA-1:0] ad, input bit wv,
                      input logic [TA-1:0] wt, input logic [WIDTH-1:0] wd,
                      input bit fl);
    alloc_valid = av;
    alloc_dest  = ad;
    wb_valid    = wv;
    wb_tag      = wt;
    wb_data     = wd;
    flush       = fl;
    #1;
    check("ready", 32'(alloc_ready), 32'(rob_q.size() < ENTRIES));
    check("tag", 32'(alloc_tag), 32'(next_tag));
    check("empty", 32'(empty), 32'(rob_q.size() == 0));
    model_step(av, ad, wv, wt, wd, fl);
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic alloc(input logic [RA-1:0] d);
    step(1'b1, d, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wback(input logic [TA-1:0] t, input logic [WIDTH-1:0] d);
    step(1'b0, '0, 1'b1, t, d, 1'b0);
  endtask

  task automatic check_cleared();
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_ready", 32'(alloc_ready), 32'h1);
    check("rst_tag", 32'(alloc_tag), 32'h0);
    check("rst_we", 32'(commit_we), 32'h0);
  endtask

  // Two-cycle synchronous-looking reset pulse.
  task automatic do_reset();
    alloc_valid = 1'b0;
    wb_valid    = 1'b0;
    flush       = 1'b0;
    rst_n       = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_cleared();
    check("rst_reg", 32'(commit_reg), 32'h0);
    check("rst_data", 32'(commit_data), 32'h0);
    rst_n = 1'b1;
  endtask

  // Reset asserted between clock edges must clear outputs immediately.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [RA-1:0]    rd;
    logic [TA-1:0]    rt;
    logic [WIDTH-1:0] rw;
    bit               rav;
    bit               rwv;
    bit               rfl;

    rst_n       = 1'b0;
    alloc_valid = 1'b0;
    alloc_dest  = '0;
    wb_valid    = 1'b0;
    wb_tag      = '0;
    wb_data     = '0;
    flush       = 1'b0;
    do_reset();

    // In-order single instruction: two-cycle writeback-to-commit latency.
    alloc(6'd3);
    wback(3'd0, 16'h1234);
    check("inorder_no_bypass", 32'(commit_we), 32'h0);
    idle();
    check("inorder_we", 32'(commit_we), 32'h1);
    check("inorder_reg", 32'(commit_reg), 32'h3);
    check("inorder_data", 32'(commit_data), 32'h1234);
    idle();
    check("inorder_we_drop", 32'(commit_we), 32'h0);
    check("inorder_empty", 32'(empty), 32'h1);

    // Out-of-order completion, in-order retirement.
    do_reset();
    alloc(6'd5);
    alloc(6'd6);
    alloc(6'd7);
    wback(3'd2, 16'hCCCC);
    wback(3'd1, 16'hBBBB);
    wback(3'd0, 16'hAAAA);
    check("ooo_wait", 32'(commit_we), 32'h0);
    idle();
    check("ooo_c0", 32'({commit_reg, commit_data}), 32'({6'd5, 16'hAAAA}));
    idle();
    check("ooo_c1", 32'({commit_reg, commit_data}), 32'({6'd6, 16'hBBBB}));
    idle();
    check("ooo_c2", 32'({commit_reg, commit_data}), 32'({6'd7, 16'hCCCC}));
    check("ooo_c2_we", 32'(commit_we), 32'h1);
    async_reset();

    // Fill, reject a ninth allocation, then wrap the tail.
    for (int i = 0; i < ENTRIES; i++) alloc(RA'(i + 1));
    check("full_count", 32'(count), 32'(ENTRIES));
    check("full_ready", 32'(alloc_ready), 32'h0);
    alloc(6'd40);
    check("full_ignored", 32'(count), 32'(ENTRIES));
    wback(3'd0, 16'h0A0A);
    idle();
    check("full_commit", 32'(commit_we), 32'h1);
    check("full_count7", 32'(count), 32'(ENTRIES - 1));
    check("full_ready1", 32'(alloc_ready), 32'h1);
    check("wrap_tag", 32'(alloc_tag), 32'h0);
    wback(3'd1, 16'h1111);
    wback(3'd1, 16'h2222);
    check("first_wins", 32'(commit_data), 32'h1111);
    idle();
    idle();

    // Destination register 0 retires silently.
    do_reset();
    alloc(6'd0);
    wback(3'd0, 16'hFFFF);
    check("r0_count1", 32'(count), 32'h1);
    idle();
    check("r0_we", 32'(commit_we), 32'h0);
    check("r0_count0", 32'(count), 32'h0);
    check("r0_next_tag", 32'(alloc_tag), 32'h1);

    // Flush with concurrent allocate and writeback.
    for (int i = 0; i < 4; i++) alloc(RA'(10 + i));
    wback(3'd3, 16'h3333);
    wback(3'd2, 16'h2222);
    step(1'b1, 6'd20, 1'b1, 3'd4, 16'h4444, 1'b1);
    check("flush_count", 32'(count), 32'h0);
    check("flush_empty", 32'(empty), 32'h1);
    check("flush_we", 32'(commit_we), 32'h0);
    check("flush_tag", 32'(alloc_tag), 32'h0);
    repeat (3) idle();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rav = ($urandom_range(0, 99) < 60);
      rd  = RA'($urandom);
      if ($urandom_range(0, 7) == 0) rd = '0;
      rwv = ($urandom_range(0, 99) < 55);
      rt  = TA'($urandom);
      if (rob_q.size() > 0 && $urandom_range(0, 3) != 0)
        rt = rob_q[$urandom_range(0, rob_q.size() - 1)].tag;
      rw  = WIDTH'($urandom);
      rfl = ($urandom_range(0, 59) == 0);
      step(rav, rd, rwv, rt, rw, rfl);
      if ($urandom_range(0, 149) == 0) async_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
